dfp_sig_mul_seq: RTL and testbench

- Sequential digit-serial BCD significand multiplier.
- Sits directly upstream of the 128-bit DFP multiply stage and drives that stage's significand-product input and done qualifier.
- Multiplies two N-digit unsigned BCD significands into a 2N-digit BCD product.
- Uses a precomputed multiple table (1a..9a) and one multiplier digit per cycle, so latency is fixed and small in area.

---
 rtl/dfp_sig_mul_seq_if.sv | 15 +
 rtl/dfp_sig_mul_seq.sv | 195 +++++++++++++++++++
 tb/tb_dfp_sig_mul_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dfp_sig_mul_seq_if.sv
// Handshake/bus bundle for the digit-serial BCD significand multiplier.
// master drives the start pulse and operands; slave returns product and status.
interface dfp_sig_mul_seq_if #(
  parameter int N = 34
);
  logic           ld;
  logic [4*N-1:0] a;
  logic [4*N-1:0] b;
  logic [8*N-1:0] p;
  logic           done;
  logic           busy;

  modport master (output ld, a, b, input p, done, busy);
  modport slave  (input ld, a, b, output p, done, busy);
endinterface

// File: rtl/dfp_sig_mul_seq.sv
// Sequential digit-serial BCD significand multiplier.
// A table of multiples 1a..9a is built in PRE (one BCD add per edge), then
// MUL consumes one multiplier digit per edge, LS-first, shifting the partial
// sum right one digit per step. One finalize edge writes p and raises done,
// giving done on the (N+9)th ce-qualified edge after the accepting ld edge.
// Optional feature macro: DFPSEQMUL_ZSKIP_EN (zero operand short-cuts to DONE).
module dfp_sig_mul_seq #(
  parameter int N = 34
) (
  input logic              clk,
  input logic              rst_n,
  input logic              ce,
  dfp_sig_mul_seq_if.slave bus
);
  localparam int DW = 4 * N;
  localparam int HW = 4 * (N + 1);
  localparam int SW = 4 * (N + 2);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state_r;
  state_t         next_state_s;
  logic [DW-1:0]  a_r;
  logic [DW-1:0]  b_r;
  logic [HW-1:0]  mult_r [1:9];
  logic [HW-1:0]  acc_hi_r;
  logic [DW-1:0]  acc_lo_r;
  logic [CW-1:0]  cnt_r;
  logic [2*DW-1:0] p_r;
  logic           done_r;
  logic           busy_r;
  logic           zpend_r;

  logic           zero_s;
  logic           pre_last_s;
  logic           mul_last_s;
  logic [3:0]     dig_s;
  logic [HW-1:0]  add_x_s;
  logic [HW-1:0]  add_y_s;
  logic [SW-1:0]  sum_s;

  // Digit-serial BCD add: per-digit carry chain with +6 correction; the
  // result is one digit wider than the operands to hold the final carry.
  function automatic logic [SW-1:0] bcd_add(input logic [HW-1:0] x,
                                            input logic [HW-1:0] y);
    logic [SW-1:0] r;
    logic [4:0]    s;
    logic          c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < N + 1; i++) begin
      s = {1'b0, x[4*i +: 4]} + {1'b0, y[4*i +: 4]} + {4'b0000, c};
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i +: 4] = s[3:0];
    end
    r[SW-1 -: 4] = {3'b000, c};
    return r;
  endfunction

`ifdef DFPSEQMUL_ZSKIP_EN
  assign zero_s = (bus.a == {DW{1'b0}}) || (bus.b == {DW{1'b0}});
`else
  assign zero_s = 1'b0;
`endif

  assign pre_last_s = (cnt_r == CW'(7));
  assign mul_last_s = (cnt_r == CW'(N));

  assign bus.p    = p_r;
  assign bus.done = done_r;
  assign bus.busy = busy_r;

  // Shared adder operand select: table build in PRE, accumulate otherwise.
  always_comb begin
    add_x_s = acc_hi_r;
    add_y_s = '0;
    dig_s   = 4'd0;
    if (state_r == PRE) begin
      add_x_s = mult_r[1];
      for (int k = 2; k <= 8; k++) begin
        add_x_s = (cnt_r == CW'(k - 1)) ? mult_r[k] : add_x_s;
      end
      add_y_s = {4'd0, a_r};
    end else begin
      dig_s = (cnt_r < CW'(N)) ? b_r[{cnt_r, 2'b00} +: 4] : 4'd0;
      // digit 0 and non-BCD digits select zero, so a bad digit cannot stall
      for (int k = 1; k <= 9; k++) begin
        add_y_s = (dig_s == 4'(k)) ? mult_r[k] : add_y_s;
      end
    end
    sum_s = bcd_add(add_x_s, add_y_s);
  end

  // Next-state logic; ld restarts from any state and wins over the final MUL edge.
  always_comb begin
    next_state_s = state_r;
    if (bus.ld) begin
      next_state_s = zero_s ? DONE : PRE;
    end else begin
      case (state_r)
        IDLE:    next_state_s = IDLE;
        PRE:     next_state_s = pre_last_s ? MUL : PRE;
        MUL:     next_state_s = mul_last_s ? DONE : MUL;
        DONE:    next_state_s = DONE;
        default: next_state_s = IDLE;
      endcase
    end
  end

  // State register, frozen while ce is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else if (ce) begin
      state_r <= next_state_s;
    end
  end

  // Operand latch, multiple table, accumulator, digit counter and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      for (int k = 1; k <= 9; k++) begin
        mult_r[k] <= '0;
      end
      acc_hi_r <= '0;
      acc_lo_r <= '0;
      cnt_r    <= '0;
      p_r      <= '0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      zpend_r  <= 1'b0;
    end else if (ce) begin
      if (bus.ld) begin
        a_r       <= bus.a;
        b_r       <= bus.b;
        mult_r[1] <= {4'd0, bus.a};
        cnt_r     <= '0;
        done_r    <= 1'b0;
        busy_r    <= ~zero_s;
        zpend_r   <= zero_s;
      end else begin
        case (state_r)
          PRE: begin
            for (int k = 2; k <= 9; k++) begin
              if (cnt_r == CW'(k - 2)) begin
                mult_r[k] <= sum_s[HW-1:0];
              end
            end
            if (pre_last_s) begin
              cnt_r    <= '0;
              acc_hi_r <= '0;
              acc_lo_r <= '0;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
          MUL: begin
            if (mul_last_s) begin
              // top digit of acc_hi is zero here: product fits 2N digits
              p_r    <= {acc_hi_r[DW-1:0], acc_lo_r};
              done_r <= 1'b1;
              busy_r <= 1'b0;
            end else begin
              acc_hi_r <= sum_s[SW-1:4];
              acc_lo_r <= {sum_s[3:0], acc_lo_r[DW-1:4]};
              cnt_r    <= cnt_r + CW'(1);
            end
          end
          DONE: begin
            if (zpend_r) begin
              p_r     <= '0;
              done_r  <= 1'b1;
              zpend_r <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dfp_sig_mul_seq.sv
// Directed self-checking bench for dfp_sig_mul_seq (N=34).
module tb_dfp_sig_mul_seq;
  localparam int N  = 34;
  localparam int DW = 4 * N;
  localparam int PW = 8 * N;
  localparam logic [PW-1:0] ZERO = '0;

`ifdef DFPSEQMUL_ZSKIP_EN
  localparam int   ZLAT  = 1;
  localparam logic ZBUSY = 1'b0;
`else
  localparam int   ZLAT  = 43;
  localparam logic ZBUSY = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic ce;
  int   n_chk  = 0;
  int   n_fail = 0;

  dfp_sig_mul_seq_if #(.N(N)) bus ();
  dfp_sig_mul_seq #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .ce(ce), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [DW-1:0] av, input logic [DW-1:0] bv);
    bus.a  = av;
    bus.b  = bv;
    bus.ld = 1'b1;
    ce     = 1'b1;
    step();
    bus.ld = 1'b0;
  endtask

  task automatic idle_edges(input string tag, input int n);
    int spur;
    spur = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (bus.done !== 1'b0) spur++;
    end
    chk({tag, " no done"}, PW'(spur), ZERO);
  endtask

  task automatic run_op(input string tag, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                        input int stall_at, input int stall_len,
                        input logic [PW-1:0] exp_p, input int exp_lat, input logic exp_busy);
    logic [PW-1:0] old_p;
    int lat;
    int busy_bad;
    int p_early;
    int e;
    old_p    = bus.p;
    lat      = -1;
    busy_bad = 0;
    p_early  = 0;
    e        = 0;
    start(av, bv);
    while (lat < 0 && e < 200) begin
      ce = (e >= stall_at && e < stall_at + stall_len) ? 1'b0 : 1'b1;
      step();
      e++;
      if (bus.done === 1'b1) begin
        lat = e;
      end else begin
        if (bus.busy !== exp_busy) busy_bad++;
        if (bus.p !== old_p) p_early++;
      end
    end
    ce = 1'b1;
    chk({tag, " latency"}, PW'(lat), PW'(exp_lat));
    chk({tag, " product"}, bus.p, exp_p);
    chk({tag, " busy at done"}, PW'(bus.busy), ZERO);
    chk({tag, " busy during op"}, PW'(busy_bad), ZERO);
    chk({tag, " p held before done"}, PW'(p_early), ZERO);
    step();
    step();
    chk({tag, " done held"}, PW'(bus.done), PW'(1'b1));
    chk({tag, " p held"}, bus.p, exp_p);
  endtask

  initial begin
    logic [DW-1:0] nines;
    logic [PW-1:0] exp_max;
    rst_n  = 1'b0;
    ce     = 1'b0;
    bus.ld = 1'b0;
    bus.a  = '0;
    bus.b  = '0;
    #12;
    chk("reset p", bus.p, ZERO);
    chk("reset done", PW'(bus.done), ZERO);
    chk("reset busy", PW'(bus.busy), ZERO);
    rst_n = 1'b1;
    ce    = 1'b1;
    step();
    step();

    run_op("basic 1x1", DW'(1), DW'(1), -1, 0, PW'(1), 43, 1'b1);

    for (int i = 0; i < N; i++) nines[4*i +: 4] = 4'h9;
    for (int i = 0; i < 2 * N; i++) begin
      if (i == 0)          exp_max[4*i +: 4] = 4'h1;
      else if (i < N)      exp_max[4*i +: 4] = 4'h0;
      else if (i == N)     exp_max[4*i +: 4] = 4'h8;
      else                 exp_max[4*i +: 4] = 4'h9;
    end
    run_op("max nines", nines, nines, -1, 0, exp_max, 43, 1'b1);

    run_op("stall", DW'(32'h12345678), DW'(32'h87654321), 20, 5,
           PW'(64'h1082152022374638), 48, 1'b1);

    start(DW'(2), DW'(3));
    idle_edges("restart first op", 19);
    run_op("restart", DW'(7), DW'(6), -1, 0, PW'(8'h42), 43, 1'b1);

    start(DW'(3), DW'(3));
    idle_edges("final-edge first op", 42);
    run_op("ld on final edge", DW'(2), DW'(2), -1, 0, PW'(4'h4), 43, 1'b1);

    start(DW'(9), DW'(9));
    idle_edges("reset mid-op", 29);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset p", bus.p, ZERO);
    chk("async reset done", PW'(bus.done), ZERO);
    chk("async reset busy", PW'(bus.busy), ZERO);
    step();
    rst_n = 1'b1;
    idle_edges("after reset", 50);
    run_op("post-reset 5x5", DW'(5), DW'(5), -1, 0, PW'(8'h25), 43, 1'b1);

    run_op("zero operand", DW'(0), DW'(8'h99), -1, 0, ZERO, ZLAT, ZBUSY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
